// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch with one outstanding request, output+skid buffer and redirect kill
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {IDLE, FETCH, FULL, KILL} state_t;

  state_t      state;
  logic [31:0] kill_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        consume;
  logic        ack_ok;
  logic        outstanding;
  logic        skid_next;
  logic [31:0] redirect_aligned;
  logic        unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Edge qualifiers: consumption, usable ack data, and whether the skid slot is occupied after this edge
  always_comb begin
    consume          = valid_out & ~Stall;
    ack_ok           = imem_ack & imem_req & (state == FETCH);
    outstanding      = imem_req & ~imem_ack;
    redirect_aligned = {redirect_pc[31:2], 2'b00};
    skid_next        = 1'b0;
    if (valid_out) begin
      if (consume) skid_next = skid_valid & ack_ok;
      else         skid_next = skid_valid | ack_ok;
    end
  end

  // Fetch FSM, request register and the two-entry instruction buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      kill_pc    <= RESET_PC;
      valid_out  <= 1'b0;
      instr_out  <= NOP;
      pc_out     <= 32'h0;
      skid_valid <= 1'b0;
      skid_instr <= NOP;
      skid_pc    <= 32'h0;
    end else if (Redirect) begin
      // Redirect wins over stall and ack data: flush everything buffered
      valid_out  <= 1'b0;
      instr_out  <= NOP;
      pc_out     <= 32'h0;
      skid_valid <= 1'b0;
      if (outstanding) begin
        // Old request must complete before the new one may be issued
        state   <= KILL;
        kill_pc <= redirect_aligned;
      end else begin
        state     <= FETCH;
        imem_req  <= 1'b1;
        imem_addr <= redirect_aligned;
      end
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        KILL: begin
          if (imem_ack) begin
            state     <= FETCH;
            imem_addr <= kill_pc;
          end
        end
        default: begin
          if (consume) begin
            if (skid_valid) begin
              instr_out  <= skid_instr;
              pc_out     <= skid_pc;
              skid_valid <= ack_ok;
              if (ack_ok) begin
                skid_instr <= imem_rdata;
                skid_pc    <= imem_addr;
              end
            end else if (ack_ok) begin
              instr_out <= imem_rdata;
              pc_out    <= imem_addr;
            end else begin
              valid_out <= 1'b0;
              instr_out <= NOP;
              pc_out    <= 32'h0;
            end
          end else if (ack_ok) begin
            if (!valid_out) begin
              valid_out <= 1'b1;
              instr_out <= imem_rdata;
              pc_out    <= imem_addr;
            end else begin
              skid_valid <= 1'b1;
              skid_instr <= imem_rdata;
              skid_pc    <= imem_addr;
            end
          end
          if (ack_ok) imem_addr <= imem_addr + 32'd4;
          state    <= skid_next ? FULL : FETCH;
          imem_req <= ~skid_next;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] RST_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic        Redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'hDEADBEEF;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  bit          rnd_mode = 1'b0;
  int          wcnt = 0;
  int          n_deliv = 0;
  logic [31:0] exp_pc = RST_PC;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: expected pc stream, request stability, plus the memory responder
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc    = RST_PC;
      prev_hold = 1'b0;
      wcnt      = 0;
      imem_ack  = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("req_hold", {31'b0, imem_req}, 32'd1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      if (!valid_out) begin
        chk("empty_instr", instr_out, NOP);
        chk("empty_pc", pc_out, 32'h0);
      end else begin
        chk("pc_seq", pc_out, exp_pc);
        chk("instr_data", instr_out, mem_word(pc_out));
      end
      if (Redirect) exp_pc = {redirect_pc[31:2], 2'b00};
      else if (valid_out && !Stall) begin
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      if (!imem_req) begin
        wcnt     = 0;
        imem_ack = 1'b0;
      end else begin
        imem_ack = rnd_mode ? ($urandom_range(0, 2) == 0) : (wcnt >= lat - 1);
        wcnt     = imem_ack ? 0 : wcnt + 1;
      end
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEADBEEF;
      prev_hold  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
    end
  end

  task automatic boot_check(input string tag);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk({tag, "_c0_req"}, {31'b0, imem_req}, 32'd0);
    @(negedge clk); #1;
    chk({tag, "_c1_req"}, {31'b0, imem_req}, 32'd1);
    chk({tag, "_c1_addr"}, imem_addr, RST_PC);
    chk({tag, "_c1_valid"}, {31'b0, valid_out}, 32'd0);
  endtask

  initial begin
    int n;
    int n0;
    bit found;
    logic [31:0] p0;
    logic [31:0] rp;

    rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);

    // Zero-wait memory: one instruction per cycle
    boot_check("zw");
    @(negedge clk); #1;
    chk("zw_c2_valid", {31'b0, valid_out}, 32'd1);
    chk("zw_c2_pc", pc_out, 32'h0);
    n = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (valid_out) n++;
    end
    chk("zw_tput", n, 20);

    // Stall for 4 cycles: output holds, skid fills, request drops
    @(posedge clk); #1; Stall = 1'b1;
    @(negedge clk); #1;
    chk("st_valid", {31'b0, valid_out}, 32'd1);
    p0 = pc_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("st_pc_hold", pc_out, p0);
      chk("st_req_low", {31'b0, imem_req}, 32'd0);
    end
    @(posedge clk); #1; Stall = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Redirect together with Stall while both entries full
    Stall = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rs_full_valid", {31'b0, valid_out}, 32'd1);
    chk("rs_full_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1;
    rp = $urandom;
    Redirect = 1'b1; redirect_pc = rp;
    @(posedge clk); #1;
    Redirect = 1'b0; Stall = 1'b0;
    @(negedge clk); #1;
    chk("rs_valid", {31'b0, valid_out}, 32'd0);
    chk("rs_instr", instr_out, NOP);
    chk("rs_req", {31'b0, imem_req}, 32'd1);
    chk("rs_addr", imem_addr, {rp[31:2], 2'b00});
    repeat (8) @(posedge clk);
    #1;

    // Three-cycle ack latency
    rst_n = 1'b0; lat = 3;
    repeat (2) @(posedge clk);
    #1;
    boot_check("l3");
    for (int i = 2; i < 4; i++) begin
      @(negedge clk); #1;
      chk("l3_req_held", {31'b0, imem_req}, 32'd1);
      chk("l3_addr_held", imem_addr, RST_PC);
      chk("l3_valid_wait", {31'b0, valid_out}, 32'd0);
    end
    @(negedge clk); #1;
    chk("l3_c4_valid", {31'b0, valid_out}, 32'd1);
    chk("l3_c4_pc", pc_out, 32'h0);
    n = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (valid_out) n++;
    end
    chk("l3_tput", n, 10);

    // Redirect while the request to 0x10 is outstanding (latency 2)
    @(posedge clk); #1;
    rst_n = 1'b0; lat = 2;
    repeat (2) @(posedge clk);
    #1;
    boot_check("l2");
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (imem_req && imem_addr == 32'h10 && wcnt == 0) found = 1'b1;
    end
    chk("kill_found_0x10", {31'b0, found}, 32'd1);
    Redirect = 1'b1; redirect_pc = 32'h00000102;
    @(posedge clk); #1;
    Redirect = 1'b0;
    @(negedge clk); #1;
    chk("kill_valid", {31'b0, valid_out}, 32'd0);
    chk("kill_addr_held", imem_addr, 32'h10);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (imem_addr != 32'h10) found = 1'b1;
    end
    chk("kill_next_addr", imem_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (valid_out) found = 1'b1;
    end
    chk("kill_first_valid", {31'b0, found}, 32'd1);
    chk("kill_first_pc", pc_out, 32'h100);

    // Asynchronous reset in the middle of a request
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (imem_req && wcnt == 0) found = 1'b1;
    end
    chk("mr_found_req", {31'b0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_req", {31'b0, imem_req}, 32'd0);
    chk("mr_valid", {31'b0, valid_out}, 32'd0);
    chk("mr_instr", instr_out, NOP);
    chk("mr_pc", pc_out, 32'h0);
    chk("mr_addr", imem_addr, RST_PC);
    repeat (2) @(posedge clk);
    #1;
    boot_check("mr");

    // Random ack timing, stalls and redirects against the model
    rnd_mode = 1'b1;
    n0 = n_deliv;
    repeat (2000) begin
      @(posedge clk); #1;
      Stall       = ($urandom_range(0, 9) < 3);
      Redirect    = ($urandom_range(0, 31) == 0);
      redirect_pc = $urandom;
    end
    @(posedge clk); #1;
    Stall = 1'b0; Redirect = 1'b0;
    repeat (4) @(posedge clk);
    chk("rand_progress", {31'b0, (n_deliv - n0) > 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
